// File: rtl/spi_slave_fifo_pkg.sv
// Shared constants and FSM encoding for the SPI slave with rx/tx byte FIFOs.
package spi_slave_fifo_pkg;

  localparam int unsigned ByteW    = 8;
  localparam int unsigned MaxDepth = 128;
  localparam int unsigned DefDepth = 64;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } spi_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_slave_sfifo.sv
// Synchronous show-ahead FIFO; push when full and pop when empty are ignored.
module spi_slave_sfifo
  import spi_slave_fifo_pkg::*;
#(
  parameter int unsigned Depth = DefDepth,
  parameter int unsigned Width = ByteW
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic [Width-1:0]         din,
  input  logic                     pop,
  output logic [Width-1:0]         dout,
  output logic [cnt_w(Depth)-1:0]  count
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = cnt_w(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, empty, wr_en, rd_en;

  always_comb begin
    full  = (count_q == CW'(Depth));
    empty = (count_q == '0);
    wr_en = push & ~full;
    rd_en = pop & ~empty;
    dout  = empty ? '0 : mem_q[rd_ptr_q];
    count = count_q;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave bit engine: input synchronizers, edge detect, select FSM and byte shifters.
module spi_slave_shifter
  import spi_slave_fifo_pkg::*;
#(
  parameter bit         CPOL = 1'b0,
  parameter bit         CPHA = 1'b0,
  parameter logic [7:0] FILL = 8'h00
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sclk,
  input  logic       n_cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_pop,
  output logic [7:0] rx_data,
  output logic       rx_push
);

  logic [1:0] sclk_sync_q, ncs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, ncs_prev_q;
  logic       sclk_s, ncs_s, mosi_s;
  logic       lead_edge, trail_edge, sample_edge, shift_edge, ncs_fall;
  logic [7:0] tx_next, rx_next;

  spi_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] tx_q;
  logic [6:0] rx_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sclk_sync_q <= {2{CPOL}};
      ncs_sync_q  <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= CPOL;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      ncs_sync_q  <= {ncs_sync_q[0], n_cs};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sclk_prev_q <= sclk_sync_q[1];
      ncs_prev_q  <= ncs_sync_q[1];
    end
  end

  always_comb begin
    sclk_s      = sclk_sync_q[1];
    ncs_s       = ncs_sync_q[1];
    mosi_s      = mosi_sync_q[1];
    lead_edge   = (sclk_s != sclk_prev_q) && (sclk_s != CPOL);
    trail_edge  = (sclk_s != sclk_prev_q) && (sclk_s == CPOL);
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    ncs_fall    = ncs_prev_q & ~ncs_s;
    tx_next     = tx_valid ? tx_data : FILL;
    rx_next     = {rx_q, mosi_s};
    miso        = tx_q[7];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      tx_q      <= 8'h00;
      rx_q      <= 7'h00;
      rx_data   <= 8'h00;
      rx_push   <= 1'b0;
      tx_pop    <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      tx_pop  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ncs_fall) begin
            state_q   <= StActive;
            miso_oe   <= 1'b1;
            bit_cnt_q <= 3'd0;
            tx_q      <= tx_next;
            tx_pop    <= tx_valid;
          end
        end
        StActive: begin
          if (ncs_s) begin
            // Deselect aborts any partial byte; the half-sent tx byte is dropped.
            state_q   <= StIdle;
            miso_oe   <= 1'b0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 8'h00;
          end else begin
            if (sample_edge) begin
              rx_q      <= rx_next[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_data <= rx_next;
                rx_push <= 1'b1;
                if (CPHA) begin
                  tx_q   <= tx_next;
                  tx_pop <= tx_valid;
                end
              end
            end
            if (shift_edge) begin
              // Count zero on a shift edge marks a byte boundary: CPHA=0 loads the
              // next byte here, CPHA=1 already loaded it and must hold the MSB.
              if (bit_cnt_q == 3'd0) begin
                if (!CPHA) begin
                  tx_q   <= tx_next;
                  tx_pop <= tx_valid;
                end
              end else begin
                tx_q <= {tx_q[6:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave with tx and rx byte FIFOs, sticky rx overrun flag and rx occupancy.
module spi_slave_fifo
  import spi_slave_fifo_pkg::*;
#(
  parameter bit          CPOL  = 1'b0,
  parameter bit          CPHA  = 1'b0,
  parameter int unsigned DEPTH = DefDepth,
  parameter logic [7:0]  FILL  = 8'h00
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sclk,
  input  logic       n_cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] m_din,
  input  logic       m_wrreq,
  output logic       m_full,
  output logic [7:0] s_dout,
  input  logic       s_rdreq,
  output logic       have_msg,
  output logic [7:0] len,
  output logic       overrun,
  input  logic       clr_ovr
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic [7:0]    tx_head, rx_byte;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_valid, tx_pop, rx_push, rx_full;

  spi_slave_sfifo #(
    .Depth (DEPTH),
    .Width (ByteW)
  ) u_tx_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (m_wrreq),
    .din   (m_din),
    .pop   (tx_pop),
    .dout  (tx_head),
    .count (tx_count)
  );

  spi_slave_sfifo #(
    .Depth (DEPTH),
    .Width (ByteW)
  ) u_rx_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (rx_push),
    .din   (rx_byte),
    .pop   (s_rdreq),
    .dout  (s_dout),
    .count (rx_count)
  );

  spi_slave_shifter #(
    .CPOL (CPOL),
    .CPHA (CPHA),
    .FILL (FILL)
  ) u_shifter (
    .clk      (clk),
    .n_rst    (n_rst),
    .sclk     (sclk),
    .n_cs     (n_cs),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_head),
    .tx_valid (tx_valid),
    .tx_pop   (tx_pop),
    .rx_data  (rx_byte),
    .rx_push  (rx_push)
  );

  always_comb begin
    tx_valid = (tx_count != '0);
    m_full   = (tx_count == CW'(DEPTH));
    rx_full  = (rx_count == CW'(DEPTH));
    have_msg = (rx_count != '0);
    len      = 8'(rx_count);
  end

  // Set has priority over clear so an overrun coinciding with clr_ovr is not lost.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overrun <= 1'b0;
    end else if (rx_push && rx_full) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: one instance per CPOL/CPHA mode, all driven by a common master.
module tb_spi_slave_fifo;

  localparam int unsigned Depth = 8;
  localparam logic [7:0]  Fill  = 8'h5A;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       sclk_base = 1'b0;
  logic       n_cs = 1'b1;
  logic       mosi = 1'b0;
  logic       m_wrreq = 1'b0;
  logic       s_rdreq = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] m_din = 8'h00;

  logic [3:0] sclk_v, miso_v, oe_v, full_v, have_v, ovr_v;
  logic [7:0] sdout_v [4];
  logic [7:0] len_v [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam bit Cpol = (g >= 2);
    localparam bit Cpha = (g % 2 == 1);
    assign sclk_v[g] = sclk_base ^ Cpol;
    spi_slave_fifo #(
      .CPOL  (Cpol),
      .CPHA  (Cpha),
      .DEPTH (Depth),
      .FILL  (Fill)
    ) u_dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .sclk     (sclk_v[g]),
      .n_cs     (n_cs),
      .mosi     (mosi),
      .miso     (miso_v[g]),
      .miso_oe  (oe_v[g]),
      .m_din    (m_din),
      .m_wrreq  (m_wrreq),
      .m_full   (full_v[g]),
      .s_dout   (sdout_v[g]),
      .s_rdreq  (s_rdreq),
      .have_msg (have_v[g]),
      .len      (len_v[g]),
      .overrun  (ovr_v[g]),
      .clr_ovr  (clr_ovr)
    );
  end

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         lat = -1;
  logic [7:0] exp_rx [$];
  logic [7:0] exp_miso [$];
  logic [7:0] got_m [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rst_miso%0d", g), 32'(miso_v[g]), 32'd0);
      check($sformatf("rst_oe%0d", g), 32'(oe_v[g]), 32'd0);
      check($sformatf("rst_full%0d", g), 32'(full_v[g]), 32'd0);
      check($sformatf("rst_have%0d", g), 32'(have_v[g]), 32'd0);
      check($sformatf("rst_len%0d", g), 32'(len_v[g]), 32'd0);
      check($sformatf("rst_ovr%0d", g), 32'(ovr_v[g]), 32'd0);
      check($sformatf("rst_dout%0d", g), 32'(sdout_v[g]), 32'd0);
    end
  endtask

  // One bit = mosi set, leading edge, trailing edge, 6 clk apart (sclk = clk/18).
  // On the last bit, optionally pulse s_rdreq pop_at clk after the leading edge.
  task automatic send_bits(input logic [7:0] b, input int nb, input int pop_at,
                           input int sim_len, output int lat_o);
    int len0;
    lat_o = -1;
    len0  = 0;
    for (int i = 0; i < nb; i++) begin
      mosi = b[7-i];
      tick(6);
      for (int g = 0; g < 4; g += 2) got_m[g][7-i] = miso_v[g];
      if (i == 7) len0 = int'(len_v[0]);
      sclk_base = 1'b1;
      if (i == 7) begin
        for (int c = 1; c <= 6; c++) begin
          if (c == pop_at) s_rdreq = 1'b1;
          tick(1);
          s_rdreq = 1'b0;
          if (c == pop_at) begin
            check("simul_len0", 32'(len_v[0]), 32'(sim_len));
            check("simul_len2", 32'(len_v[2]), 32'(sim_len));
          end
          if (lat_o < 0 && int'(len_v[0]) != len0) lat_o = c;
        end
      end else begin
        tick(6);
      end
      for (int g = 1; g < 4; g += 2) got_m[g][7-i] = miso_v[g];
      sclk_base = 1'b0;
      tick(6);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_m, input bit keep,
                           input int pop_at, input int sim_len);
    logic [7:0] em;
    exp_miso.push_back(exp_m);
    if (keep) exp_rx.push_back(b);
    send_bits(b, 8, pop_at, sim_len, lat);
    em = exp_miso.pop_front();
    for (int g = 0; g < 4; g++) check($sformatf("miso_byte%0d", g), 32'(got_m[g]), 32'(em));
  endtask

  task automatic cs_low();
    n_cs = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    n_cs = 1'b1;
    tick(6);
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      e = exp_rx.pop_front();
      for (int g = 0; g < 4; g++) begin
        check($sformatf("have%0d", g), 32'(have_v[g]), 32'd1);
        check($sformatf("rx_byte%0d", g), 32'(sdout_v[g]), 32'(e));
      end
      s_rdreq = 1'b1;
      tick(1);
      s_rdreq = 1'b0;
    end
    for (int g = 0; g < 4; g++) check($sformatf("drained_len%0d", g), 32'(len_v[g]), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dummy;
    tick(3);
    check_reset();
    n_rst = 1'b1;
    tick(4);

    // Preloaded tx byte, single rx byte.
    m_din   = 8'hA5;
    m_wrreq = 1'b1;
    tick(1);
    m_wrreq = 1'b0;
    cs_low();
    for (int g = 0; g < 4; g++) check($sformatf("oe_active%0d", g), 32'(oe_v[g]), 32'd1);
    send_byte(8'h3C, 8'hA5, 1'b1, -1, 0);
    cs_high();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("oe_idle%0d", g), 32'(oe_v[g]), 32'd0);
      check($sformatf("len1_%0d", g), 32'(len_v[g]), 32'd1);
    end
    drain(1);

    // Four-byte burst with tx empty.
    cs_low();
    for (int k = 1; k <= 4; k++) send_byte(8'(k), Fill, 1'b1, -1, 0);
    cs_high();
    for (int g = 0; g < 4; g++) check($sformatf("len4_%0d", g), 32'(len_v[g]), 32'd4);
    drain(4);

    // Deselect after 5 bits, then a clean byte.
    cs_low();
    send_bits(8'hF0, 5, -1, 0, dummy);
    cs_high();
    for (int g = 0; g < 4; g++) check($sformatf("partial_len%0d", g), 32'(len_v[g]), 32'd0);
    cs_low();
    send_byte(8'h81, Fill, 1'b1, -1, 0);
    cs_high();
    drain(1);

    // Overflow: Depth+1 bytes, last one dropped.
    cs_low();
    for (int k = 0; k <= Depth; k++) send_byte(8'(8'h10 + k), Fill, (k < Depth), -1, 0);
    cs_high();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("ovf_len%0d", g), 32'(len_v[g]), 32'(Depth));
      check($sformatf("ovf_flag%0d", g), 32'(ovr_v[g]), 32'd1);
    end
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    for (int g = 0; g < 4; g++) check($sformatf("ovf_clr%0d", g), 32'(ovr_v[g]), 32'd0);
    drain(Depth);

    // Pop coinciding with an rx write at len=3.
    cs_low();
    send_byte(8'h31, Fill, 1'b1, -1, 0);
    check("lat_found", 32'(lat > 0), 32'd1);
    send_byte(8'h32, Fill, 1'b1, -1, 0);
    send_byte(8'h33, Fill, 1'b1, -1, 0);
    for (int g = 0; g < 4; g++) check($sformatf("pre_len%0d", g), 32'(len_v[g]), 32'd3);
    for (int g = 0; g < 4; g++) check($sformatf("pop_head%0d", g), 32'(sdout_v[g]),
                                      32'(exp_rx[0]));
    void'(exp_rx.pop_front());
    send_byte(8'h34, Fill, 1'b1, lat, 3);
    cs_high();
    for (int g = 0; g < 4; g++) check($sformatf("post_len%0d", g), 32'(len_v[g]), 32'd3);
    drain(3);

    // Reset pulse mid-byte.
    m_din   = 8'h77;
    m_wrreq = 1'b1;
    tick(1);
    m_wrreq = 1'b0;
    cs_low();
    send_bits(8'hAA, 4, -1, 0, dummy);
    n_rst = 1'b0;
    tick(1);
    check_reset();
    n_cs  = 1'b1;
    n_rst = 1'b1;
    tick(6);
    cs_low();
    send_byte(8'hC3, Fill, 1'b1, -1, 0);
    cs_high();
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
